pc_control: RTL and testbench

PC_CONTROL -- requirements
Module: pc_control

---
 rtl/pc_defs.sv | 26 ++
 rtl/pc_next_calc.sv | 31 +++
 rtl/pc_control.sv | 92 +++++++++
 tb/tb_pc_control.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_defs.sv
// Shared definitions for the PC sequencer: state encodings, opcode field values
// and the HALT operand pattern.
package pc_defs;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'b00,
        ST_DECODE = 2'b01,
        ST_EXEC   = 2'b10,
        ST_HALT   = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        OP_ALU  = 2'b00,
        OP_BEQZ = 2'b01,
        OP_JMP  = 2'b10,
        OP_SYS  = 2'b11
    } opcode_e;

    localparam logic [5:0] HALT_PATTERN = 6'h3F;

    // SYS opcode with the all-ones operand halts; any other SYS operand is a NOP.
    function automatic logic is_halt(input logic [7:0] ir);
        return (opcode_e'(ir[7:6]) == OP_SYS) && (ir[5:0] == HALT_PATTERN);
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC arithmetic for the EXEC state; all sums wrap modulo 2^WIDTH.
module pc_next_calc
    import pc_defs::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] ir,
    input  logic             zero,
    output logic [WIDTH-1:0] next_pc
);

    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] off_sext;
    logic [WIDTH-1:0] jmp_tgt;
    opcode_e          opcode;

    always_comb begin
        opcode   = opcode_e'(ir[7:6]);
        pc_inc   = pc + WIDTH'(1);
        off_sext = {{(WIDTH-6){ir[5]}}, ir[5:0]};
        jmp_tgt  = {{(WIDTH-6){1'b0}}, ir[5:0]};
        next_pc  = pc_inc;
        case (opcode)
            OP_BEQZ: next_pc = zero ? (pc_inc + off_sext) : pc_inc;
            OP_JMP:  next_pc = jmp_tgt;
            default: next_pc = pc_inc;
        endcase
    end

endmodule

// File: rtl/pc_control.sv
// Three-phase FETCH/DECODE/EXEC instruction sequencer driving an external pc register,
// with a sticky HALT state left only through reset.
module pc_control
    import pc_defs::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] PC,
    input  logic [WIDTH-1:0] Instr,
    input  logic             Zero,
    input  logic             Stall,
    output logic [WIDTH-1:0] NextPC,
    output logic             PCWrite,
    output logic             IRLoad,
    output logic             RegWrite,
    output logic [1:0]       State,
    output logic             Halted
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] calc_next;
    logic             halt_instr;
    logic             alu_instr;

    pc_next_calc #(.WIDTH(WIDTH)) u_pc_next_calc (
        .pc      (PC),
        .ir      (ir_q),
        .zero    (Zero),
        .next_pc (calc_next)
    );

    always_comb begin
        halt_instr = is_halt(ir_q[7:0]);
        alu_instr  = (opcode_e'(ir_q[7:6]) == OP_ALU);
    end

    // The pc register loads every cycle, so "hold" means echoing PC back.
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        NextPC   = PC;
        IRLoad   = 1'b0;
        PCWrite  = 1'b0;
        RegWrite = 1'b0;
        if (!Reset) begin
            NextPC = '0;
        end else if (!Stall) begin
            case (state_q)
                ST_FETCH: begin
                    IRLoad  = 1'b1;
                    ir_d    = Instr;
                    state_d = ST_DECODE;
                end
                ST_DECODE: begin
                    state_d = ST_EXEC;
                end
                ST_EXEC: begin
                    if (halt_instr) begin
                        state_d = ST_HALT;
                    end else begin
                        NextPC   = calc_next;
                        PCWrite  = 1'b1;
                        RegWrite = alu_instr;
                        state_d  = ST_FETCH;
                    end
                end
                default: begin
                    state_d = ST_HALT;
                end
            endcase
        end
    end

    always_comb begin
        State  = state_q;
        Halted = Reset && (state_q == ST_HALT);
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_q <= ST_FETCH;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

endmodule

// File: tb/tb_pc_control.sv
// Directed bench for pc_control: a phase/IR model checked on every falling edge,
// plus literal expectations at the key points of each scenario.
module tb_pc_control;

    logic       clk;
    logic       Reset;
    logic [7:0] PC;
    logic [7:0] Instr;
    logic       Zero;
    logic       Stall;
    logic [7:0] NextPC;
    logic       PCWrite;
    logic       IRLoad;
    logic       RegWrite;
    logic [1:0] State;
    logic       Halted;

    int vectors     = 0;
    int miscompares = 0;

    pc_control #(.WIDTH(8)) dut (
        .clk      (clk),
        .Reset    (Reset),
        .PC       (PC),
        .Instr    (Instr),
        .Zero     (Zero),
        .Stall    (Stall),
        .NextPC   (NextPC),
        .PCWrite  (PCWrite),
        .IRLoad   (IRLoad),
        .RegWrite (RegWrite),
        .State    (State),
        .Halted   (Halted)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0..3 = fetch/decode/exec/halt, plus the latched instruction.
    int m_phase = 0;
    int m_ir    = 0;
    bit m_valid = 0;

    always @(posedge clk) begin
        if (!Reset) begin
            m_phase = 0;
            m_ir    = 0;
            m_valid = 1;
        end else if (m_valid && !Stall) begin
            if (m_phase == 0) begin
                m_ir    = Instr;
                m_phase = 1;
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (m_phase == 2) begin
                m_phase = (m_ir == 8'hFF) ? 3 : 0;
            end
        end
    end

    always @(negedge clk) begin
        int e_next, e_pcw, e_irl, e_rw, e_halt, op, off;
        if (m_valid) begin
            e_next = PC; e_pcw = 0; e_irl = 0; e_rw = 0;
            e_halt = (m_phase == 3) ? 1 : 0;
            op  = m_ir / 64;
            off = m_ir % 64;
            if (!Reset) begin
                e_next = 0;
                e_halt = 0;
            end else if (!Stall) begin
                if (m_phase == 0) e_irl = 1;
                if (m_phase == 2 && m_ir != 8'hFF) begin
                    e_pcw = 1;
                    if (op == 0) begin
                        e_rw = 1;
                        e_next = (PC + 1) % 256;
                    end else if (op == 1) begin
                        if (off >= 32) off = off - 64;
                        e_next = Zero ? (PC + 1 + off + 256) % 256 : (PC + 1) % 256;
                    end else if (op == 2) begin
                        e_next = off;
                    end else begin
                        e_next = (PC + 1) % 256;
                    end
                end
            end
            chk("model_state", State, m_phase);
            chk("model_nextpc", NextPC, e_next);
            chk("model_pcwrite", PCWrite, e_pcw);
            chk("model_irload", IRLoad, e_irl);
            chk("model_regwrite", RegWrite, e_rw);
            chk("model_halted", Halted, e_halt);
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts in FETCH, leaves the DUT back in FETCH (or HALT for 0xFF).
    task automatic run_instr(input logic [7:0] pc, input logic [7:0] ins, input logic z,
                             input int exp_next, input int exp_rw);
        PC = pc; Instr = ins; Zero = z;
        #1 chk("fetch_irload", IRLoad, 1);
        step();
        chk("decode_state", State, 1);
        step();
        chk("exec_state", State, 2);
        chk("exec_nextpc", NextPC, exp_next);
        chk("exec_regwrite", RegWrite, exp_rw);
        step();
    endtask

    initial begin
        Reset = 1'b0; PC = 8'h00; Instr = 8'h05; Zero = 1'b0; Stall = 1'b1;
        step();
        step();
        chk("reset_state", State, 0);
        chk("reset_nextpc", NextPC, 0);
        chk("reset_irload_stall", IRLoad, 0);
        Reset = 1'b1; Stall = 1'b0;

        run_instr(8'h00, 8'h05, 1'b0, 8'h01, 1);
        run_instr(8'h10, 8'h7C, 1'b1, 8'h0D, 0);
        run_instr(8'h10, 8'h7C, 1'b0, 8'h11, 0);
        run_instr(8'hFF, 8'h05, 1'b0, 8'h00, 1);
        run_instr(8'h20, 8'h8A, 1'b0, 8'h0A, 0);
        run_instr(8'h02, 8'h7C, 1'b1, 8'hFF, 0);
        run_instr(8'h02, 8'h45, 1'b1, 8'h08, 0);
        run_instr(8'h30, 8'hC0, 1'b1, 8'h31, 0);

        // stall three cycles in DECODE
        PC = 8'h40; Instr = 8'h05; Zero = 1'b0;
        step();
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_state", State, 1);
            chk("stall_nextpc", NextPC, 8'h40);
            chk("stall_strobes", {IRLoad, PCWrite, RegWrite}, 0);
            step();
        end
        Stall = 1'b0;
        #1 chk("stall_release_state", State, 1);
        step();
        chk("resume_exec_nextpc", NextPC, 8'h41);
        chk("resume_exec_regwrite", RegWrite, 1);
        step();

        // halt and stay halted
        PC = 8'h50; Instr = 8'hFF;
        step();
        step();
        chk("halt_exec_nextpc", NextPC, 8'h50);
        chk("halt_exec_pcwrite", PCWrite, 0);
        step();
        for (int i = 0; i < 10; i++) begin
            chk("halted_state", State, 3);
            chk("halted_flag", Halted, 1);
            chk("halted_nextpc", NextPC, 8'h50);
            step();
        end
        Reset = 1'b0; PC = 8'h00;
        #1 chk("halt_reset_nextpc", NextPC, 0);
        chk("halt_reset_halted", Halted, 0);
        step();
        Reset = 1'b1;
        chk("post_halt_state", State, 0);
        chk("post_halt_nextpc", NextPC, 0);

        // reset during EXEC
        PC = 8'h60; Instr = 8'h05;
        step();
        step();
        Reset = 1'b0;
        #1 chk("exec_reset_pcwrite", PCWrite, 0);
        chk("exec_reset_regwrite", RegWrite, 0);
        chk("exec_reset_nextpc", NextPC, 0);
        step();
        Reset = 1'b1;
        chk("exec_reset_state", State, 0);

        run_instr(8'h60, 8'h05, 1'b0, 8'h61, 1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
